// File: rtl/uart_tx_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// uart_tx_sequencer_pkg
// Shared types and constants for the UART transmit sequencer: FSM state
// encoding, byte width, and the FIFO entry layout {byte_cnt, data}.
// -----------------------------------------------------------------------------
package uart_tx_sequencer_pkg;

  localparam int UART_BYTE_W = 8;
  localparam int WORD_W      = 32;
  localparam int CNT_W       = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2
  } tx_state_e;

  // byte_cnt holds (number of bytes to send - 1).
  typedef struct packed {
    logic [CNT_W-1:0]  byte_cnt;
    logic [WORD_W-1:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/uart_word_fifo.sv
// -----------------------------------------------------------------------------
// uart_word_fifo
// Synchronous FIFO of {byte_cnt, data} entries with a separate level counter.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   i_wr_en        : write request; accepted only when not full
//   i_wr_entry     : entry to store
//   i_rd_en        : pop request; ignored when empty
//   o_rd_entry     : entry at the head (valid when not empty)
//   o_full/o_empty : derived from the registered level
//   o_level        : occupancy, 0..DEPTH
//   o_reject       : write requested while full (entry dropped)
// -----------------------------------------------------------------------------
module uart_word_fifo
  import uart_tx_sequencer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_wr_en,
  input  fifo_entry_t      i_wr_entry,
  input  logic             i_rd_en,
  output fifo_entry_t      o_rd_entry,
  output logic             o_full,
  output logic             o_empty,
  output logic [LVL_W-1:0] o_level,
  output logic             o_reject
);

  localparam int PTR_W = $clog2(DEPTH);

  fifo_entry_t      r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_level;
  logic             w_push;
  logic             w_pop;

  // Fullness is judged on the registered level, so a pop in the same cycle
  // never makes room for a write.
  assign o_full     = (r_level == LVL_W'(DEPTH));
  assign o_empty    = (r_level == '0);
  assign o_level    = r_level;
  assign w_push     = i_wr_en && !o_full;
  assign w_pop      = i_rd_en && !o_empty;
  assign o_reject   = i_wr_en && o_full;
  assign o_rd_entry = r_mem[r_rd_ptr];

  // NOTE: storage is deliberately not reset; clearing the pointers and level
  // already makes every old entry unreachable, and unreset RAM maps to plain
  // memory cells.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_wr_entry;
    end
  end

  // Pointers are exactly PTR_W bits wide, so increment wraps modulo DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_sequencer.sv
// -----------------------------------------------------------------------------
// uart_tx_sequencer
// Buffers CPU-written 32-bit words and feeds them, LSB byte first, to the
// UART transmitter one frame at a time (start pulse out, done pulse back).
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   wr_en_i         : one-cycle word write strobe
//   wr_data_i       : word to transmit
//   byte_cnt_i      : bytes to send from this word, minus one
//   tx_done_i       : frame-complete pulse from the UART (used only in WAIT)
//   ovf_clr_i       : clears overflow_o (a same-cycle rejected write wins)
//   tx_start_o      : one-cycle start pulse to the UART
//   tx_data_o       : byte being sent
//   busy_o          : a word is being sequenced
//   fifo_full_o     : FIFO holds FIFO_DEPTH words
//   fifo_empty_o    : FIFO holds no words
//   level_o         : FIFO occupancy
//   overflow_o      : sticky, set when a write is rejected
// -----------------------------------------------------------------------------
module uart_tx_sequencer
  import uart_tx_sequencer_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en_i,
  input  logic [DATA_WIDTH-1:0]  wr_data_i,
  input  logic [CNT_W-1:0]       byte_cnt_i,
  input  logic                   tx_done_i,
  input  logic                   ovf_clr_i,
  output logic                   tx_start_o,
  output logic [UART_BYTE_W-1:0] tx_data_o,
  output logic                   busy_o,
  output logic                   fifo_full_o,
  output logic                   fifo_empty_o,
  output logic [LVL_W-1:0]       level_o,
  output logic                   overflow_o
);

  tx_state_e             r_state;
  tx_state_e             w_next_state;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [CNT_W-1:0]      r_idx;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_overflow;
  logic                  w_pop;
  logic                  w_advance;
  logic                  w_reject;
  fifo_entry_t           w_wr_entry;
  fifo_entry_t           w_head;

  assign w_wr_entry.byte_cnt = byte_cnt_i;
  assign w_wr_entry.data     = wr_data_i;

  uart_word_fifo #(
    .DEPTH (FIFO_DEPTH),
    .LVL_W (LVL_W)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_wr_en    (wr_en_i),
    .i_wr_entry (w_wr_entry),
    .i_rd_en    (w_pop),
    .o_rd_entry (w_head),
    .o_full     (fifo_full_o),
    .o_empty    (fifo_empty_o),
    .o_level    (level_o),
    .o_reject   (w_reject)
  );

  // NOTE: state and datapath registers use non-blocking assignments so every
  // flop samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  // NOTE: every output of this block is defaulted first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    w_pop        = 1'b0;
    w_advance    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (!fifo_empty_o) begin
          w_pop        = 1'b1;
          w_next_state = ST_START;
        end
      end
      ST_START: w_next_state = ST_WAIT;
      ST_WAIT: begin
        // tx_done_i is only honoured here; strays in IDLE/START are dropped.
        if (tx_done_i) begin
          if (r_idx == r_cnt) begin
            w_next_state = ST_IDLE;
          end else begin
            w_advance    = 1'b1;
            w_next_state = ST_START;
          end
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift <= '0;
      r_idx   <= '0;
      r_cnt   <= '0;
    end else if (w_pop) begin
      r_shift <= w_head.data;
      r_idx   <= '0;
      r_cnt   <= w_head.byte_cnt;
    end else if (w_advance) begin
      r_shift <= r_shift >> UART_BYTE_W;
      r_idx   <= r_idx + 1'b1;
    end
  end

  // A rejected write in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk) begin
    if (rst)            r_overflow <= 1'b0;
    else if (w_reject)  r_overflow <= 1'b1;
    else if (ovf_clr_i) r_overflow <= 1'b0;
  end

  assign tx_start_o = (r_state == ST_START);
  assign busy_o     = (r_state != ST_IDLE);
  assign tx_data_o  = r_shift[UART_BYTE_W-1:0];
  assign overflow_o = r_overflow;

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_sequencer
// Queue-based reference model of the sequencer, compared against the DUT on
// every falling edge, plus directed scenarios with literal expectations and a
// randomized traffic phase. A UART responder returns tx_done_i a programmable
// number of cycles after each start pulse; extra "stray" done pulses can be
// injected on request.
// -----------------------------------------------------------------------------
module tb_uart_tx_sequencer;

  localparam int DEPTH = 4;
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic             clk        = 1'b0;
  logic             rst        = 1'b1;
  logic             wr_en_i    = 1'b0;
  logic [31:0]      wr_data_i  = '0;
  logic [1:0]       byte_cnt_i = '0;
  logic             tx_done_i  = 1'b0;
  logic             ovf_clr_i  = 1'b0;
  logic             tx_start_o;
  logic [7:0]       tx_data_o;
  logic             busy_o;
  logic             fifo_full_o;
  logic             fifo_empty_o;
  logic [LVL_W-1:0] level_o;
  logic             overflow_o;

  uart_tx_sequencer #(.FIFO_DEPTH(DEPTH), .DATA_WIDTH(32), .LVL_W(LVL_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en_i      (wr_en_i),
    .wr_data_i    (wr_data_i),
    .byte_cnt_i   (byte_cnt_i),
    .tx_done_i    (tx_done_i),
    .ovf_clr_i    (ovf_clr_i),
    .tx_start_o   (tx_start_o),
    .tx_data_o    (tx_data_o),
    .busy_o       (busy_o),
    .fifo_full_o  (fifo_full_o),
    .fifo_empty_o (fifo_empty_o),
    .level_o      (level_o),
    .overflow_o   (overflow_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- reference model ----------------
  // Words waiting in the FIFO, bytes still to go for the word in flight,
  // whether a word is in flight, whether this cycle carries a start pulse.
  logic [33:0] m_words [$];
  logic [7:0]  m_bytes [$];
  logic [7:0]  m_log   [$];
  logic        m_busy  = 1'b0;
  logic        m_start = 1'b0;
  logic        m_ovf   = 1'b0;
  logic [7:0]  m_data  = 8'h00;

  task automatic model_step();
    logic        was_full;
    logic [33:0] w;
    was_full = (m_words.size() == DEPTH);
    if (rst) begin
      m_words.delete();
      m_bytes.delete();
      m_busy  = 1'b0;
      m_start = 1'b0;
      m_ovf   = 1'b0;
      m_data  = 8'h00;
    end else begin
      if (!m_busy) begin
        if (m_words.size() > 0) begin
          w = m_words.pop_front();
          for (int i = 0; i <= int'(w[33:32]); i++) m_bytes.push_back(w[8*i +: 8]);
          m_data  = m_bytes[0];
          m_busy  = 1'b1;
          m_start = 1'b1;
          m_log.push_back(m_data);
        end
      end else if (m_start) begin
        m_start = 1'b0;
      end else if (tx_done_i) begin
        void'(m_bytes.pop_front());
        if (m_bytes.size() == 0) begin
          m_busy = 1'b0;
        end else begin
          m_data  = m_bytes[0];
          m_start = 1'b1;
          m_log.push_back(m_data);
        end
      end
      if (wr_en_i && !was_full) m_words.push_back({byte_cnt_i, wr_data_i});
      if (wr_en_i && was_full) m_ovf = 1'b1;
      else if (ovf_clr_i)      m_ovf = 1'b0;
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    model_step();
  end

  // ---------------- compare + DUT event logging ----------------
  logic       chk_en = 1'b0;
  int         dut_starts = 0;
  logic [7:0] dut_log   [$];
  int         start_cyc [$];
  int         done_cyc  [$];

  always @(negedge clk) begin
    if (chk_en) begin
      check("tx_start", tx_start_o, m_start);
      check("tx_data", tx_data_o, m_data);
      check("busy", busy_o, m_busy);
      check("level", level_o, m_words.size());
      check("full", fifo_full_o, m_words.size() == DEPTH);
      check("empty", fifo_empty_o, m_words.size() == 0);
      check("overflow", overflow_o, m_ovf);
    end
    if (tx_start_o === 1'b1) begin
      dut_starts++;
      dut_log.push_back(tx_data_o);
      start_cyc.push_back(cyc);
    end
    if (tx_done_i === 1'b1) done_cyc.push_back(cyc);
  end

  // ---------------- UART responder ----------------
  logic auto_en    = 1'b1;
  int   auto_dly   = 5;
  int   stray_reqs = 0;

  initial begin
    int cdn = 0;
    int stray_seen = 0;
    forever begin
      @(posedge clk);
      #2;
      tx_done_i = 1'b0;
      if (cdn > 0) begin
        cdn--;
        if (cdn == 0) tx_done_i = 1'b1;
      end
      if (stray_reqs != stray_seen) begin
        stray_seen = stray_reqs;
        tx_done_i  = 1'b1;
      end
      if (tx_start_o && auto_en) cdn = auto_dly;
    end
  end

  // ---------------- stimulus helpers ----------------
  int last_wr_cyc = 0;

  task automatic write_word(input logic [31:0] d, input logic [1:0] c, input logic clr = 1'b0);
    @(posedge clk);
    #1;
    wr_en_i     = 1'b1;
    wr_data_i   = d;
    byte_cnt_i  = c;
    ovf_clr_i   = clr;
    last_wr_cyc = cyc;
    @(posedge clk);
    #1;
    wr_en_i   = 1'b0;
    ovf_clr_i = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!(busy_o === 1'b0 && fifo_empty_o === 1'b1) && n < budget);
    check("drain", {busy_o, fifo_empty_o}, 2'b01);
  endtask

  task automatic wait_starts(input int target, input int budget);
    int n = 0;
    while (dut_starts < target && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("start_wait", dut_starts >= target, 1'b1);
  endtask

  task automatic check_log(input string name, input int base, input int mbase,
                           input logic [7:0] exp[$]);
    check({name, "_count"}, dut_log.size() - base, exp.size());
    check({name, "_mcount"}, m_log.size() - mbase, exp.size());
    for (int i = 0; i < exp.size(); i++) begin
      check(name, dut_log[base+i], exp[i]);
      check({name, "_model"}, m_log[mbase+i], exp[i]);
    end
  endtask

  // ---------------- scenarios ----------------
  initial begin
    int         b, mb, sb, db, s0;
    logic [7:0] e [$];
    logic [31:0] d;
    logic [1:0]  c;

    @(posedge clk);
    #1;
    chk_en = 1'b1;
    check("rst_level", level_o, 0);
    check("rst_empty", fifo_empty_o, 1'b1);
    check("rst_full", fifo_full_o, 1'b0);
    check("rst_data", tx_data_o, 8'h00);
    check("rst_busy", busy_o, 1'b0);
    check("rst_start", tx_start_o, 1'b0);
    check("rst_ovf", overflow_o, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Full word, done 5 cycles after each start.
    b = dut_log.size(); mb = m_log.size(); sb = start_cyc.size();
    auto_dly = 5;
    write_word(32'h44332211, 2'd3);
    wait_idle(200);
    e = {8'h11, 8'h22, 8'h33, 8'h44};
    check_log("full_word", b, mb, e);
    check("first_start_lat", start_cyc[sb] - last_wr_cyc, 2);
    check("start_spacing", start_cyc[sb+1] - start_cyc[sb], 6);
    check("full_word_busy", busy_o, 1'b0);

    // Single byte then a two-byte word back to back.
    b = dut_log.size(); mb = m_log.size(); sb = start_cyc.size(); db = done_cyc.size();
    write_word(32'hDEADBEEF, 2'd0);
    write_word(32'h000000A5, 2'd1);
    wait_idle(200);
    e = {8'hEF, 8'hA5, 8'h00};
    check_log("b2b", b, mb, e);
    check("b2b_gap", start_cyc[sb+1] - done_cyc[db], 2);

    // Overflow with the UART stalled.
    b = dut_log.size(); mb = m_log.size();
    auto_en = 1'b0;
    write_word(32'h000000C3, 2'd0);
    for (int k = 0; k < 5; k++) write_word(32'h10 + 32'(k), 2'd0);
    check("ovf_level", level_o, 4);
    check("ovf_full", fifo_full_o, 1'b1);
    check("ovf_set", overflow_o, 1'b1);
    @(posedge clk); #1; ovf_clr_i = 1'b1;
    @(posedge clk); #1; ovf_clr_i = 1'b0;
    check("ovf_cleared", overflow_o, 1'b0);
    write_word(32'h000000EE, 2'd0, 1'b1);
    check("ovf_set_wins", overflow_o, 1'b1);
    check("ovf_level_hold", level_o, 4);
    auto_en = 1'b1;
    @(posedge clk); #1; stray_reqs++;
    wait_idle(400);
    e = {8'hC3, 8'h10, 8'h11, 8'h12, 8'h13};
    check_log("ovf_bytes", b, mb, e);

    // Stray done in IDLE, then in START.
    @(posedge clk); #1; stray_reqs++;
    repeat (2) @(posedge clk);
    #1;
    check("stray_idle_busy", busy_o, 1'b0);
    check("stray_idle_level", level_o, 0);
    b = dut_log.size(); mb = m_log.size();
    write_word(32'h00009A5B, 2'd1);
    @(posedge clk); #1;
    check("stray_in_start", tx_start_o, 1'b1);
    stray_reqs++;
    wait_idle(200);
    e = {8'h5B, 8'h9A};
    check_log("stray_bytes", b, mb, e);

    // Pointer wrap-around: ten words, queue held below three.
    b = dut_log.size(); mb = m_log.size();
    e.delete();
    for (int k = 0; k < 10; k++) begin
      int g = 0;
      while (m_words.size() >= 3 && g < 200) begin
        @(posedge clk); #1; g++;
      end
      d = $urandom;
      c = 2'($urandom_range(0, 3));
      auto_dly = $urandom_range(1, 4);
      for (int i = 0; i <= int'(c); i++) e.push_back(d[8*i +: 8]);
      write_word(d, c);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    wait_idle(2000);
    check_log("wrap", b, mb, e);

    // Reset during WAIT of byte 1 with two words queued.
    auto_dly = 6;
    s0 = dut_starts; db = done_cyc.size();
    write_word(32'hA4A3A2A1, 2'd3);
    write_word(32'h0000B1B0, 2'd1);
    write_word(32'h000000C0, 2'd0);
    wait_starts(s0 + 2, 100);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_level", level_o, 0);
    check("mid_rst_busy", busy_o, 1'b0);
    check("mid_rst_data", tx_data_o, 8'h00);
    check("mid_rst_empty", fifo_empty_o, 1'b1);
    s0 = dut_starts;
    repeat (12) @(posedge clk);
    #1;
    check("mid_rst_no_start", dut_starts - s0, 0);
    check("mid_rst_late_done", done_cyc.size() > db, 1'b1);

    // Randomized traffic.
    repeat (400) begin
      @(posedge clk); #1;
      wr_en_i    = ($urandom_range(0, 3) == 0);
      wr_data_i  = $urandom;
      byte_cnt_i = 2'($urandom_range(0, 3));
      ovf_clr_i  = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 49) == 0) stray_reqs++;
      if ($urandom_range(0, 19) == 0) auto_dly = $urandom_range(1, 6);
    end
    @(posedge clk); #1;
    wr_en_i   = 1'b0;
    ovf_clr_i = 1'b0;
    wait_idle(3000);
    repeat (3) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
